xor_gate_unit: RTL and testbench



---
 rtl/xor_gate_unit_pkg.sv | 16 +
 rtl/xor_skid_buffer.sv | 98 +++++++++
 rtl/xor_gate_unit.sv | 55 +++++
 tb/tb_xor_gate_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/xor_gate_unit_pkg.sv
// Shared definitions for the XOR stage.
// Contents: occupancy encoding for 2-entry skid buffers and the legal
// upper bound on datapath width. Nothing here depends on a particular
// instance's WIDTH; that stays a module parameter.
package xor_gate_unit_pkg;

    // Occupancy of a head + skid pair. FULL means both entries hold data.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_HEAD  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    localparam int unsigned WIDTH_MAX = 64;

endpackage

// File: rtl/xor_skid_buffer.sv
// Two-entry valid/ready skid buffer with strict FIFO ordering.
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   in_data        payload offered by the producer
//   in_valid       producer has a payload this cycle
//   in_ready       registered; high exactly when the skid entry is empty
//   out_data       payload at the head (output register)
//   out_valid      head holds a valid payload
//   out_ready      consumer takes the head this cycle
module xor_skid_buffer #(
    parameter int unsigned DW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);
    import xor_gate_unit_pkg::*;

    occ_e          state_q;
    occ_e          state_d;
    logic [DW-1:0] head_q;
    logic [DW-1:0] skid_q;
    logic          ready_q;

    logic in_xfer;
    logic out_xfer;
    logic load_head;
    logic head_from_skid;
    logic load_skid;

    always_comb begin
        in_xfer        = in_valid && ready_q;
        out_xfer       = (state_q != OCC_EMPTY) && out_ready;
        state_d        = state_q;
        load_head      = 1'b0;
        head_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            OCC_EMPTY: begin
                if (in_xfer) begin
                    load_head = 1'b1;
                    state_d   = OCC_HEAD;
                end
            end
            OCC_HEAD: begin
                if (out_xfer) begin
                    // Draining head: a same-cycle input replaces it directly.
                    if (in_xfer) begin
                        load_head = 1'b1;
                    end else begin
                        state_d = OCC_EMPTY;
                    end
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_d   = OCC_FULL;
                end
            end
            OCC_FULL: begin
                // ready_q is low here, so no input can arrive this cycle.
                if (out_xfer) begin
                    load_head      = 1'b1;
                    head_from_skid = 1'b1;
                    state_d        = OCC_HEAD;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OCC_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Registered look-ahead keeps in_ready free of any input path.
            ready_q <= (state_d != OCC_FULL);
            if (load_head) begin
                head_q <= head_from_skid ? skid_q : in_data;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = head_q;

endmodule

// File: rtl/xor_gate_unit.sv
// Registered bitwise XOR stage with valid/ready flow control.
// Computes y = a ^ b and parity = ^y, buffered through a 2-entry skid
// buffer so that one result per cycle is sustained under backpressure.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   a, b         WIDTH-bit operands
//   in_valid     operands valid; in_ready: stage can accept (registered)
//   y, parity    result at the head and its XOR-reduction
//   out_valid    y/parity valid; out_ready: consumer accepts
module xor_gate_unit #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             parity,
    output logic             out_valid,
    input  logic             out_ready
);
    import xor_gate_unit_pkg::*;

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("xor_gate_unit: WIDTH out of range");
    end

    logic [WIDTH-1:0] xor_val;
    logic             xor_par;
    logic [WIDTH:0]   head_data;

    always_comb begin
        xor_val = a ^ b;
        xor_par = ^xor_val;
    end

    xor_skid_buffer #(
        .DW(WIDTH + 1)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .in_data  ({xor_par, xor_val}),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (head_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    assign y      = head_data[WIDTH-1:0];
    assign parity = head_data[WIDTH];

endmodule

// File: tb/tb_xor_gate_unit.sv
module tb_xor_gate_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=1 instance
    logic a1 = 1'b0, b1 = 1'b0, iv1 = 1'b0, or1 = 1'b1;
    logic ir1, y1, p1, ov1;
    // WIDTH=8 instance
    logic [7:0] a8 = '0, b8 = '0;
    logic iv8 = 1'b0, or8 = 1'b1;
    logic ir8, p8, ov8;
    logic [7:0] y8;
    // WIDTH=16 instance
    logic [15:0] a16 = '0, b16 = '0;
    logic iv16 = 1'b0, or16 = 1'b1;
    logic ir16, p16, ov16;
    logic [15:0] y16;

    xor_gate_unit #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(iv1), .in_ready(ir1),
        .y(y1), .parity(p1), .out_valid(ov1), .out_ready(or1));
    xor_gate_unit #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(iv8), .in_ready(ir8),
        .y(y8), .parity(p8), .out_valid(ov8), .out_ready(or8));
    xor_gate_unit #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .in_valid(iv16), .in_ready(ir16),
        .y(y16), .parity(p16), .out_valid(ov16), .out_ready(or16));

    int checks = 0;
    int passed = 0;
    int sent = 0;
    int rcv = 0;

    // Reference for the 16-bit instance: a FIFO of capacity 2 holding
    // {parity, result} for every accepted operand pair.
    logic [16:0] q16[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock on the 16-bit instance with model update and full check.
    task automatic cyc16();
        bit          in_x;
        bit          out_x;
        logic [15:0] r;
        logic [16:0] head;
        in_x  = iv16 && (q16.size() < 2);
        out_x = or16 && (q16.size() > 0);
        r     = a16 ^ b16;
        step();
        if (out_x) begin
            void'(q16.pop_front());
            rcv = rcv + 1;
        end
        if (in_x) begin
            q16.push_back({1'($countones(r) % 2), r});
            sent = sent + 1;
        end
        chk("m_in_ready", 32'(ir16), 32'(q16.size() < 2));
        chk("m_out_valid", 32'(ov16), 32'(q16.size() > 0));
        if (q16.size() > 0) begin
            head = q16[0];
            chk("m_y", 32'(y16), 32'(head[15:0]));
            chk("m_parity", 32'(p16), 32'(head[16]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_out_valid", 32'(ov16), 32'd0);
        chk("rst_y", 32'(y16), 32'd0);
        chk("rst_parity", 32'(p16), 32'd0);
        chk("rst_in_ready", 32'(ir16), 32'd0);
        chk("rst_in_ready_w1", 32'(ir1), 32'd0);
        rst = 1'b0;
        step();
        chk("rel_in_ready_w1", 32'(ir1), 32'd1);
        chk("rel_in_ready_w8", 32'(ir8), 32'd1);
        chk("rel_in_ready_w16", 32'(ir16), 32'd1);

        // WIDTH=1 truth table, out_ready held high
        or1 = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            logic [1:0] ab;
            logic       e;
            ab  = 2'(i);
            a1  = ab[1];
            b1  = ab[0];
            iv1 = 1'b1;
            e   = (i == 1 || i == 2);
            step();
            chk("tt_out_valid", 32'(ov1), 32'd1);
            chk("tt_y", 32'(y1), 32'(e));
            chk("tt_parity", 32'(p1), 32'(e));
        end
        iv1 = 1'b0;
        step();
        chk("tt_idle_valid", 32'(ov1), 32'd0);

        // WIDTH=8 back-to-back, then idle hold
        or8 = 1'b1; iv8 = 1'b1;
        a8 = 8'hA5; b8 = 8'h0F;
        step();
        chk("w8_y0", 32'(y8), 32'h0AA);
        chk("w8_p0", 32'(p8), 32'd0);
        a8 = 8'hFF; b8 = 8'hFF;
        step();
        chk("w8_y1", 32'(y8), 32'h000);
        chk("w8_p1", 32'(p8), 32'd0);
        chk("w8_v1", 32'(ov8), 32'd1);
        a8 = 8'h3C; b8 = 8'h01;
        step();
        chk("w8_y2", 32'(y8), 32'h03D);
        chk("w8_p2", 32'(p8), 32'd1);
        iv8 = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            chk("idle_valid", 32'(ov8), 32'd0);
            chk("idle_y_hold", 32'(y8), 32'h03D);
            chk("idle_p_hold", 32'(p8), 32'd1);
        end

        // Backpressure on the 16-bit instance
        or16 = 1'b0; iv16 = 1'b1;
        a16 = 16'h1234; b16 = 16'h00FF;
        cyc16();
        chk("bp_y_first", 32'(y16), 32'h12CB);
        chk("bp_ready_1", 32'(ir16), 32'd1);
        a16 = 16'hFFFF; b16 = 16'h0001;
        cyc16();
        chk("bp_ready_2", 32'(ir16), 32'd0);
        chk("bp_hold_a", 32'(y16), 32'h12CB);
        a16 = 16'h8000; b16 = 16'h0000;
        cyc16();
        chk("bp_hold_b", 32'(y16), 32'h12CB);
        chk("bp_hold_p", 32'(p16), 32'd1);
        or16 = 1'b1;
        cyc16();
        chk("bp_drain_2nd", 32'(y16), 32'hFFFE);
        chk("bp_ready_back", 32'(ir16), 32'd1);
        cyc16();
        chk("bp_third", 32'(y16), 32'h8000);
        iv16 = 1'b0;
        cyc16();
        chk("bp_empty", 32'(ov16), 32'd0);
        chk("bp_count", 32'(sent), 32'd3);

        // Random valid/ready toggling, 1000 transactions
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < 20000 && rcv < 1000; c++) begin
            iv16 = (sent < 1000) && ($urandom_range(3) != 0);
            or16 = ($urandom_range(2) != 0);
            a16  = 16'($urandom);
            b16  = 16'($urandom);
            cyc16();
        end
        chk("rand_received", 32'(rcv), 32'd1000);
        chk("rand_sent", 32'(sent), 32'd1000);

        // Reset with both entries full
        or16 = 1'b0; iv16 = 1'b1;
        for (int unsigned i = 0; i < 3 && q16.size() < 2; i++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            cyc16();
        end
        chk("pre_rst_full", 32'(ir16), 32'd0);
        rst = 1'b1;
        step();
        q16.delete();
        chk("mrst_valid", 32'(ov16), 32'd0);
        chk("mrst_y", 32'(y16), 32'd0);
        chk("mrst_parity", 32'(p16), 32'd0);
        chk("mrst_ready", 32'(ir16), 32'd0);
        rst = 1'b0; iv16 = 1'b0; or16 = 1'b1;
        step();
        chk("post_rst_ready", 32'(ir16), 32'd1);
        chk("post_rst_valid", 32'(ov16), 32'd0);
        for (int unsigned i = 0; i < 3; i++) begin
            cyc16();
        end
        a16 = 16'h0F0F; b16 = 16'hF0F0; iv16 = 1'b1;
        cyc16();
        chk("post_rst_y", 32'(y16), 32'hFFFF);
        chk("post_rst_p", 32'(p16), 32'd0);
        iv16 = 1'b0;
        cyc16();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
